// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control and handshake bundle between the multi-cycle sequencer and the RV32I datapath
interface multicycle_sequencer_if #(parameter int CNT_W = 32);
   logic             start, halt_req, imem_ready, dmem_ready, alu_zero;
   logic [31:0]      instruction;
   logic             imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, rf_we;
   logic [2:0]       state;
   logic             busy, illegal_op, mem_timeout;
   logic [CNT_W-1:0] retired;
   modport master (
      input  start, halt_req, instruction, imem_ready, dmem_ready, alu_zero,
      output imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, rf_we,
             state, busy, illegal_op, mem_timeout, retired
   );
   modport slave (
      output start, halt_req, instruction, imem_ready, dmem_ready, alu_zero,
      input  imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, rf_we,
             state, busy, illegal_op, mem_timeout, retired
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM sequencing the shared RV32I datapath one instruction at a time
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic                     clk,
   input logic                     rst_n,
   multicycle_sequencer_if.master  bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t           state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             ill_q, ill_d, to_q, to_d, retire;
   logic [6:0]       opc;
   logic [2:0]       f3;
   logic             is_alu, is_ld, is_st, is_br, legal, taken, wait_last, unused_ir;
   assign opc       = bus.instruction[6:0];
   assign f3        = bus.instruction[14:12];
   assign unused_ir = ^{bus.instruction[31:15], bus.instruction[11:7]};
   assign is_alu    = opc == 7'b0110011 || opc == 7'b0010011;
   assign is_ld     = opc == 7'b0000011;
   assign is_st     = opc == 7'b0100011;
   assign is_br     = opc == 7'b1100011 && f3[2:1] == 2'b00;
   assign legal     = is_alu || is_ld || is_st || is_br;
   assign taken     = f3[0] ? !bus.alu_zero : bus.alu_zero;
   assign wait_last = wait_q == WAIT_W'(MEM_TIMEOUT - 1);
   assign bus.state       = state_q;
   assign bus.busy        = state_q != IDLE && state_q != HALT;
   assign bus.illegal_op  = ill_q;
   assign bus.mem_timeout = to_q;
   assign bus.retired     = retired_q;
   always_ff @(posedge clk)
      if (!rst_n) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         retired_q <= '0;
         ill_q     <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         ill_q     <= ill_d;
         to_q      <= to_d;
      end
   // wait_d defaults to zero so any state change clears the memory wait count
   always_comb begin
      state_d      = state_q;
      wait_d       = '0;
      retired_d    = retired_q;
      ill_d        = ill_q;
      to_d         = to_q;
      retire       = 1'b0;
      bus.imem_req = 1'b0;
      bus.ir_we    = 1'b0;
      bus.pc_we    = 1'b0;
      bus.pc_src   = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      bus.rf_we    = 1'b0;
      case (state_q)
         IDLE:   state_d = bus.start ? FETCH : IDLE;
         FETCH: begin
            bus.imem_req = 1'b1;
            bus.ir_we    = bus.imem_ready;
            if (bus.imem_ready) state_d = DECODE;
            else if (wait_last) begin
               to_d    = 1'b1;
               state_d = HALT;
            end else wait_d = wait_q + 1'b1;
         end
         DECODE: begin
            ill_d   = ill_q || !legal;
            state_d = legal ? EXEC : HALT;
         end
         EXEC: begin
            state_d    = (is_ld || is_st) ? MEM : WB;
            bus.pc_we  = is_br;
            bus.pc_src = is_br && taken;
            retire     = is_br;
         end
         MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = is_st;
            if (bus.dmem_ready) begin
               state_d   = WB;
               bus.pc_we = is_st;
               retire    = is_st;
            end else if (wait_last) begin
               to_d    = 1'b1;
               state_d = HALT;
            end else wait_d = wait_q + 1'b1;
         end
         WB: begin
            bus.rf_we = 1'b1;
            bus.pc_we = 1'b1;
            retire    = 1'b1;
         end
         HALT:    state_d = (bus.start && !ill_q && !to_q) ? FETCH : HALT;
         default: state_d = HALT;
      endcase
      if (retire) begin
         retired_d = retired_q + 1'b1;
         state_d   = bus.halt_req ? HALT : FETCH;
      end
   end
endmodule
